// File: rtl/spi_rx_io.sv
// -----------------------------------------------------------------------------
// spi_rx_io
//
// Memory-mapped SPI slave receiver, mode 0 with an active-low chip select.
// The external SPI pins are asynchronous to clk, so each one is synchronised
// into the clk domain. Received bits are assembled MSB-first into 32-bit
// words, and the words are buffered in a small FIFO. The CPU reads a status
// byte and pops data words over the memory bus.
//
// Parameters
//   SPI_RX_ADDR  status register address; the data register is at +4
//   FIFO_DEPTH   word FIFO depth, a power of two in the range 2..8
//
// Ports
//   clk                  system clock (the only clock)
//   rst                  asynchronous active-high reset
//   mem_bus_addr         bus address
//   mem_bus_read_en      read strobe
//   mem_bus_rdata        registered read data, one cycle after read_en
//   mem_bus_rdata_valid  high for one cycle when this block answers a read
//   i_spi_sck            external SCK (asynchronous)
//   i_spi_mosi           external MOSI (asynchronous)
//   i_spi_csn            external chip select, active-low (asynchronous)
//   o_spi_miso           slave output; 0 unless the MISO status feature is on
//   o_rx_irq             high while the FIFO holds at least one word
//
// Build option
//   SPI_RX_MISO_STATUS_EN  when defined, the status byte is shifted out on
//                          MISO (MSB first) at the start of every frame.
// -----------------------------------------------------------------------------
module spi_rx_io #(
  parameter logic [31:0] SPI_RX_ADDR = 32'h80000010,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_bus_addr,
  input  logic        mem_bus_read_en,
  output logic [31:0] mem_bus_rdata,
  output logic        mem_bus_rdata_valid,
  input  logic        i_spi_sck,
  input  logic        i_spi_mosi,
  input  logic        i_spi_csn,
  output logic        o_spi_miso,
  output logic        o_rx_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    READY,
    SHIFT
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers. Stage [1] is the synchronised level. Stage [2] is kept
  // only so that edges can be detected.
  // The CSn chain resets to 0 (asserted). WAIT_IDLE then has to see a real
  // CSn high before the FSM arms. If the chain reset to 1, a frame that was
  // still running when reset released would look like a fresh falling edge.
  // ---------------------------------------------------------------------------
  logic [2:0] sck_sync_q;
  logic [2:0] csn_sync_q;
  logic [1:0] mosi_sync_q;

  // NOTE: sequential state uses non-blocking assignments only. Combinational
  // logic is kept in always_comb, so no process reads a flop mid-update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      csn_sync_q  <= '0;
      mosi_sync_q <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], i_spi_sck};
      csn_sync_q  <= {csn_sync_q[1:0], i_spi_csn};
      mosi_sync_q <= {mosi_sync_q[0], i_spi_mosi};
    end
  end

  logic sck_rise;
  logic csn_rise;
  logic csn_fall;
  logic csn_high;
  logic mosi_s;

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign csn_rise = csn_sync_q[1] & ~csn_sync_q[2];
  assign csn_fall = ~csn_sync_q[1] & csn_sync_q[2];
  assign csn_high = csn_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];

  // ---------------------------------------------------------------------------
  // Receive FSM and shift register
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic        push_q, push_d;
  logic        frame_err_set;

  // push_q is one cycle behind the 32nd SCK edge. The FIFO then writes
  // shift_q, which stays stable because SCK phases last at least 4 clk.
  always_comb begin
    // NOTE: every signal gets a default first so that no path leaves one
    // unassigned. This keeps latches out of the comb logic.
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    push_d        = 1'b0;
    frame_err_set = 1'b0;

    unique case (state_q)
      WAIT_IDLE: begin
        if (csn_high) state_d = READY;
      end
      READY: begin
        if (csn_fall) begin
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (csn_rise) begin
          // A frame that ends off a word boundary drops its partial word.
          if (bit_cnt_q != 5'd0) frame_err_set = 1'b1;
          state_d = READY;
        end else if (sck_rise) begin
          shift_d   = {shift_q[30:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) push_d = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic rd_status;
  logic rd_data;

  assign rd_status = mem_bus_read_en && (mem_bus_addr == SPI_RX_ADDR);
  assign rd_data   = mem_bus_read_en && (mem_bus_addr == SPI_RX_ADDR + 32'd4);

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          overflow_set;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign pop        = rd_data & ~fifo_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still
  // succeeds when the CPU reads at that moment.
  assign push_ok      = push_q & (~fifo_full | pop);
  assign overflow_set = push_q & fifo_full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop);
  end

  // NOTE: the storage array is not reset. The pointers and the count define
  // which entries are valid, so the array can map onto plain RAM or flops
  // that have no reset.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= shift_q;
  end

  // ---------------------------------------------------------------------------
  // Status flags and registered read port
  // ---------------------------------------------------------------------------
  logic        overflow_q, overflow_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  status;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        irq_q, irq_d;

  assign status = {4'(count_q), frame_err_q, overflow_q, fifo_full, ~fifo_empty};

  always_comb begin
    // A status read clears the sticky flags. A new event in the same cycle
    // sets the flag again, so the event is never lost.
    overflow_d  = overflow_set  | (overflow_q  & ~rd_status);
    frame_err_d = frame_err_set | (frame_err_q & ~rd_status);

    rdata_d       = '0;
    rdata_valid_d = rd_status | rd_data;
    if (rd_status)                  rdata_d = {24'h0, status};
    else if (rd_data && !fifo_empty) rdata_d = fifo_mem[rd_ptr_q];

    irq_d = ~fifo_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      frame_err_q   <= frame_err_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      irq_q         <= irq_d;
    end
  end

  assign mem_bus_rdata       = rdata_q;
  assign mem_bus_rdata_valid = rdata_valid_q;
  assign o_rx_irq            = irq_q;

  // ---------------------------------------------------------------------------
  // Optional MISO status echo
  // ---------------------------------------------------------------------------
`ifdef SPI_RX_MISO_STATUS_EN
  logic       sck_fall;
  logic [7:0] miso_sr_q, miso_sr_d;
  logic [3:0] miso_cnt_q, miso_cnt_d;
  logic       miso_q, miso_d;

  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];

  // miso_cnt counts the bits already presented. After 8 bits the line is
  // held at 0 until the frame ends.
  always_comb begin
    miso_sr_d  = miso_sr_q;
    miso_cnt_d = miso_cnt_q;
    miso_d     = miso_q;
    if (csn_high) begin
      miso_d     = 1'b0;
      miso_cnt_d = 4'd8;
    end else if (state_q == READY && csn_fall) begin
      miso_d     = status[7];
      miso_sr_d  = {status[6:0], 1'b0};
      miso_cnt_d = 4'd1;
    end else if (state_q == SHIFT && sck_fall) begin
      if (miso_cnt_q < 4'd8) begin
        miso_d     = miso_sr_q[7];
        miso_sr_d  = {miso_sr_q[6:0], 1'b0};
        miso_cnt_d = miso_cnt_q + 4'd1;
      end else begin
        miso_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_sr_q  <= '0;
      miso_cnt_q <= 4'd8;
      miso_q     <= 1'b0;
    end else begin
      miso_sr_q  <= miso_sr_d;
      miso_cnt_q <= miso_cnt_d;
      miso_q     <= miso_d;
    end
  end

  assign o_spi_miso = miso_q;
`else
  assign o_spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_io.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_io
//
// Directed testbench for spi_rx_io, built with the default parameters
// (FIFO_DEPTH = 4).
// An SPI master task drives mode-0 bits with phases of 5 clk. The bus read
// task checks the registered one-cycle read response. The single-word
// scenario runs from a table of {address, expected valid, expected data}
// records. The other scenarios are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_spi_rx_io;

  localparam logic [31:0] A_ST    = 32'h80000010;
  localparam logic [31:0] A_DT    = 32'h80000014;
  localparam logic [31:0] A_OTHER = 32'h80000018;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_bus_addr;
  logic        mem_bus_read_en;
  logic [31:0] mem_bus_rdata;
  logic        mem_bus_rdata_valid;
  logic        i_spi_sck;
  logic        i_spi_mosi;
  logic        i_spi_csn;
  logic        o_spi_miso;
  logic        o_rx_irq;

  spi_rx_io dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_bus_addr        (mem_bus_addr),
    .mem_bus_read_en     (mem_bus_read_en),
    .mem_bus_rdata       (mem_bus_rdata),
    .mem_bus_rdata_valid (mem_bus_rdata_valid),
    .i_spi_sck           (i_spi_sck),
    .i_spi_mosi          (i_spi_mosi),
    .i_spi_csn           (i_spi_csn),
    .o_spi_miso          (o_spi_miso),
    .o_rx_irq            (o_rx_irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 bit. MISO is sampled just before the SCK rising edge, which is
  // where a master would sample it.
  task automatic spi_bit(input logic b, output logic miso_smp);
    i_spi_mosi = b;
    wait_clk(5);
    miso_smp  = o_spi_miso;
    i_spi_sck = 1'b1;
    wait_clk(5);
    i_spi_sck = 1'b0;
  endtask

  task automatic spi_word(input logic [31:0] w);
    logic m;
    for (int i = 31; i >= 0; i--) spi_bit(w[i], m);
  endtask

  task automatic spi_bits(input int n);
    logic m;
    for (int i = 0; i < n; i++) spi_bit(i[0], m);
  endtask

  task automatic cs_low();
    i_spi_csn = 1'b0;
    wait_clk(5);
  endtask

  task automatic cs_high();
    wait_clk(5);
    i_spi_csn = 1'b1;
    wait_clk(8);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic valid);
    mem_bus_addr    = addr;
    mem_bus_read_en = 1'b1;
    wait_clk(1);
    mem_bus_read_en = 1'b0;
    mem_bus_addr    = '0;
    data  = mem_bus_rdata;
    valid = mem_bus_rdata_valid;
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    bus_read(addr, d, v);
    check({name, "_valid"}, {31'b0, v}, 32'd1);
    check(name, d, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d2;
    logic        v;
    logic        m;
    logic [15:0] miso_bits;
    logic [7:0]  exp_miso;

    vt[0] = '{A_ST,    1'b1, 32'h0000_0011};
    vt[1] = '{A_DT,    1'b1, 32'hDEAD_BEEF};
    vt[2] = '{A_ST,    1'b1, 32'h0000_0000};
    vt[3] = '{A_DT,    1'b1, 32'h0000_0000};
    vt[4] = '{A_OTHER, 1'b0, 32'h0000_0000};
    vt[5] = '{A_ST,    1'b1, 32'h0000_0000};

    rst             = 1'b1;
    mem_bus_addr    = '0;
    mem_bus_read_en = 1'b0;
    i_spi_sck       = 1'b0;
    i_spi_mosi      = 1'b0;
    i_spi_csn       = 1'b1;

    // Reset state
    wait_clk(3);
    check("reset_rdata",  mem_bus_rdata, 32'd0);
    check("reset_valid",  {31'b0, mem_bus_rdata_valid}, 32'd0);
    check("reset_miso",   {31'b0, o_spi_miso}, 32'd0);
    check("reset_irq",    {31'b0, o_rx_irq}, 32'd0);
    rst = 1'b0;
    wait_clk(5);
    rd_check("reset_status", A_ST, 32'h0);

    // Single word, checked from the vector table
    cs_low();
    spi_word(32'hDEAD_BEEF);
    cs_high();
    check("single_irq", {31'b0, o_rx_irq}, 32'd1);
    foreach (vt[i]) begin
      bus_read(vt[i].addr, d, v);
      check($sformatf("vec%0d_valid", i), {31'b0, v}, {31'b0, vt[i].exp_valid});
      if (vt[i].exp_valid) check($sformatf("vec%0d_data", i), d, vt[i].exp_data);
      wait_clk(1);
      check($sformatf("vec%0d_pulse", i), {31'b0, mem_bus_rdata_valid}, 32'd0);
    end
    check("single_irq_clear", {31'b0, o_rx_irq}, 32'd0);

    // Multi-word frame, drained with back-to-back reads
    cs_low();
    spi_word(32'h0102_0304);
    spi_word(32'hA5A5_A5A5);
    cs_high();
    rd_check("multi_status", A_ST, 32'h21);
    mem_bus_addr    = A_DT;
    mem_bus_read_en = 1'b1;
    wait_clk(1);
    d = mem_bus_rdata;
    wait_clk(1);
    d2 = mem_bus_rdata;
    mem_bus_read_en = 1'b0;
    mem_bus_addr    = '0;
    check("multi_word0", d, 32'h0102_0304);
    check("multi_word1", d2, 32'hA5A5_A5A5);
    rd_check("multi_empty_read", A_DT, 32'h0);
    rd_check("multi_status_end", A_ST, 32'h0);

    // Overflow: five words into a four-entry FIFO
    cs_low();
    for (int w = 1; w <= 5; w++) spi_word(32'h1111_0000 + w);
    cs_high();
    rd_check("ovf_status", A_ST, 32'h47);
    rd_check("ovf_status2", A_ST, 32'h43);
    for (int w = 1; w <= 4; w++) rd_check($sformatf("ovf_word%0d", w), A_DT, 32'h1111_0000 + w);
    rd_check("ovf_status_end", A_ST, 32'h0);
    rd_check("ovf_fifth_lost", A_DT, 32'h0);

    // Partial frame, then a clean frame
    cs_low();
    spi_bits(12);
    cs_high();
    rd_check("partial_status", A_ST, 32'h08);
    rd_check("partial_status_clr", A_ST, 32'h00);
    cs_low();
    spi_word(32'h1234_5678);
    cs_high();
    rd_check("partial_next_status", A_ST, 32'h11);
    rd_check("partial_next_word", A_DT, 32'h1234_5678);

    // Reset mid-frame: CSn stays low through reset, then 22 more bits
    cs_low();
    spi_bits(10);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
    spi_bits(22);
    wait_clk(8);
    rd_check("rstmid_status", A_ST, 32'h00);
    check("rstmid_irq", {31'b0, o_rx_irq}, 32'd0);
    cs_high();
    cs_low();
    spi_word(32'hCAFE_F00D);
    cs_high();
    rd_check("rstmid_clean_status", A_ST, 32'h11);
    rd_check("rstmid_clean_word", A_DT, 32'hCAFE_F00D);
    rd_check("rstmid_empty", A_ST, 32'h00);

    // MISO status echo with one word buffered
    cs_low();
    spi_word(32'h0F0F_0F0F);
    cs_high();
    check("miso_idle", {31'b0, o_spi_miso}, 32'd0);
    cs_low();
    miso_bits = '0;
    for (int i = 0; i < 32; i++) begin
      spi_bit(1'b0, m);
      if (i < 16) miso_bits = {miso_bits[14:0], m};
    end
    cs_high();
`ifdef SPI_RX_MISO_STATUS_EN
    exp_miso = 8'h11;
`else
    exp_miso = 8'h00;
`endif
    check("miso_byte0", {24'h0, miso_bits[15:8]}, {24'h0, exp_miso});
    check("miso_byte1", {24'h0, miso_bits[7:0]}, 32'h0);
    rd_check("miso_status", A_ST, 32'h21);
    rd_check("miso_word0", A_DT, 32'h0F0F_0F0F);
    rd_check("miso_word1", A_DT, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_rx_io.md
# spi_rx_io

Memory-mapped SPI slave receiver: the receive-side counterpart of the SPI transmit I/O peripheral. It samples an external SPI master (mode 0, CSn active-low) on the system clock, assembles MSB-first bytes into 32-bit words and buffers them in a small FIFO. The CPU reads a status byte and pops words over the same memory bus used by the transmit peripheral, at its own address pair.

## Interface
- `SPI_RX_ADDR`, default `32'h80000010`: status register address; the data register is at `SPI_RX_ADDR+4`.
- `FIFO_DEPTH`, default 4: word FIFO depth; power of two, 2..8.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `mem_bus_addr` in 32: bus address.
- `mem_bus_read_en` in 1: read strobe.
- `mem_bus_rdata` out 32: read data.
- `mem_bus_rdata_valid` out 1: this block drives the bus; it takes precedence over data memory.
- `i_spi_sck` in 1: external SCK, asynchronous.
- `i_spi_mosi` in 1: external MOSI, asynchronous.
- `i_spi_csn` in 1: external chip select, active-low, asynchronous.
- `o_spi_miso` out 1: slave output.
- `o_rx_irq` out 1: high while the FIFO is non-empty.

## Operation
- **Input synchronisation:** SCK, MOSI and CSn each pass through 2-FF synchronisers. SCK and CSn edges are detected from a third registered stage.
- **FSM states:**
  - WAIT_IDLE (reset state): ignore the bus until synchronised CSn=1, then go to READY. A reset taken mid-frame therefore never yields a misaligned word.
  - READY: on CSn falling, clear `bit_cnt` and the shift register and go to SHIFT.
  - SHIFT: on each SCK rising edge, `shift <= {shift[30:0], mosi}` and `bit_cnt` (5 bits) increments. When `bit_cnt` wraps 31→0, push `shift` into the FIFO. Several words per CSn frame are allowed.
  - SHIFT on CSn rising: if `bit_cnt`≠0, discard the partial word and set `frame_err`. Return to READY.
- **FIFO:** `FIFO_DEPTH` x 32, with wrapping read/write pointers and a count of width clog2(DEPTH)+1.
  - Push while full: word dropped, `overflow` set.
  - Push and pop in the same cycle while full: both happen, no overflow.
- **Status register** (byte, zero-extended to 32):
  - bit0 non-empty
  - bit1 full
  - bit2 `overflow` (sticky)
  - bit3 `frame_err` (sticky)
  - bits[7:4] FIFO count
  - A status read returns the flags and then clears both sticky bits. A flag set in the same cycle as the read wins and stays set.
- **Data register:** a read pops the head word. A read while empty returns 0 and leaves the pointers unchanged.
- **Bus decode:** any other address leaves `mem_bus_rdata_valid`=0 and does not disturb state.

## Timing
- **Reset values:**
  - `mem_bus_rdata`=0, `mem_bus_rdata_valid`=0, `o_spi_miso`=0, `o_rx_irq`=0.
  - FIFO empty, sticky flags 0, FSM in WAIT_IDLE.
- **SCK constraint:** SCK high and low phases must each be ≥4 clk. MOSI must be stable ≥4 clk around the SCK rising edge.
- **Capture latency:** a word enters the FIFO 4 clk after the raw 32nd SCK rising edge (2 sync + 1 edge + 1 push). `o_rx_irq` rises in the following cycle.
- **Read latency:** registered, one cycle. `read_en` in cycle N gives `rdata`/`rdata_valid` in N+1 for exactly one cycle. The pop and the sticky clear take effect at the end of cycle N.
- Back-to-back reads in consecutive cycles are supported.
- **MISO (mode 0):** changes only on synchronised SCK falling edges. It holds 0 while CSn is high.

## Configuration
- **`SPI_RX_MISO_STATUS_EN` defined:**
  - On CSn falling, the status byte is loaded into a MISO shift register, with bit7 presented first.
  - Subsequent bits shift out on SCK falling edges.
  - After 8 bits, `o_spi_miso`=0 for the rest of the frame.
- **Undefined:** `o_spi_miso` is tied to 0 and no MISO logic is generated.

## Test plan
- **Single word:** frame CSn low, 32 bits of `0xDEADBEEF`, CSn high. Expect:
  - `o_rx_irq`=1 and status=`0x11`.
  - Data read returns `0xDEADBEEF` one cycle after `read_en`.
  - Then status=`0x00` and `o_rx_irq`=0.
- **Multi-word frame:** one CSn frame carrying `0x01020304`, `0xA5A5A5A5`. Expect:
  - Status count=2.
  - Reads return the words in order.
  - A third read returns 0 with pointers unchanged.
- **Overflow:** with `FIFO_DEPTH`=4, send 5 words without reading. Expect:
  - Status=`0x47` (count 4, full, non-empty, overflow).
  - The fifth word is lost.
  - A second status read returns `0x43`.
- **Partial frame:** CSn rises after 12 bits. Expect status bit3=1 and FIFO empty. The next full 32-bit frame is captured correctly.
- **Reset mid-frame:** assert `rst` after 10 bits and release it with CSn still low, then send 22 more bits. Expect no push. After CSn high and a clean 32-bit frame, exactly that word is stored.
- **`SPI_RX_MISO_STATUS_EN`:** with 1 word buffered, start a frame. Expect the first 8 MISO bits sampled on SCK rising edges = `0x11`, then 0.
